// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback definitions: datapath widths, the hard-wired zero register
// and the write request record used by the writeback stage and the arbiter.
package wb_port_arbiter_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;

   // Writes to register 0 are discarded by the register file.
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// wb_result_fifo: buffers MDU results until an idle writeback slot.
// Each entry carries a valid bit so a younger pipeline write to the same
// register can cancel it in place; the slot still drains in order.
module wb_result_fifo #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_rd,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              squash_en,
   input  logic [ADDR_W-1:0] squash_rd,
   input  logic [ADDR_W-1:0] query_rd,
   output logic              empty,
   output logic              full,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_rd,
   output logic [DATA_W-1:0] head_data,
   output logic              pend_hit
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign head_valid = vld_q[rd_ptr_q];
   assign head_rd    = rd_mem_q[rd_ptr_q];
   assign head_data  = data_mem_q[rd_ptr_q];

   // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Valid bits: squash older matches first, then pop, then the new push wins.
   always_comb begin
      vld_d = vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (squash_en && (rd_mem_q[i] == squash_rd)) vld_d[i] = 1'b0;
      end
      if (pop)  vld_d[rd_ptr_q] = 1'b0;
      if (push) vld_d[wr_ptr_q] = 1'b1;
   end

   // Hazard lookup across all live entries; register 0 never hits.
   always_comb begin
      pend_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (rd_mem_q[i] == query_rd)) pend_hit = 1'b1;
      end
      if (query_rd == '0) pend_hit = 1'b0;
   end

   // Control state; reset empties the buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         vld_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         vld_q    <= vld_d;
      end
   end

   // Entry payload; qualified by the valid bits so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_q[wr_ptr_q]   <= push_rd;
         data_mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// writeback stream (always first) and buffered MDU results (idle slots only),
// with a starvation guard that asks the pipeline for a bubble.
module wb_port_arbiter #(
   parameter int DATA_W       = wb_port_arbiter_pkg::DATA_W,
   parameter int ADDR_W       = wb_port_arbiter_pkg::ADDR_W,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_we,
   input  logic [ADDR_W-1:0] pipe_rd,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_rd,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] query_rd,
   output logic              pend_hit,
   output logic              stall_req,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              proto_err
);

   import wb_port_arbiter_pkg::*;

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic              fifo_empty;
   logic              fifo_full;
   logic              head_valid;
   logic [ADDR_W-1:0] head_rd;
   logic [DATA_W-1:0] head_data;
   logic              push;
   logic              pop;

   wb_req_t           rf_q, rf_d;
   logic [SC_W-1:0]   starve_q, starve_d;
   logic              stall_req_q, stall_req_d;
   logic              proto_err_q, proto_err_d;

   assign mdu_ready = !fifo_full;
   assign push      = mdu_valid && mdu_ready;
   assign pop       = !pipe_we && !fifo_empty;

   wb_result_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_rd    (mdu_rd),
      .push_data  (mdu_data),
      .pop        (pop),
      .squash_en  (pipe_we),
      .squash_rd  (pipe_rd),
      .query_rd   (query_rd),
      .empty      (fifo_empty),
      .full       (fifo_full),
      .head_valid (head_valid),
      .head_rd    (head_rd),
      .head_data  (head_data),
      .pend_hit   (pend_hit)
   );

   // Priority mux: pipeline, else FIFO head; register 0 and squashed heads still use the slot.
   always_comb begin
      rf_d = '0;
      if (pipe_we) begin
         rf_d.we   = (pipe_rd != REG_ZERO);
         rf_d.rd   = pipe_rd;
         rf_d.data = pipe_data;
      end else if (!fifo_empty) begin
         rf_d.we   = head_valid && (head_rd != REG_ZERO);
         rf_d.rd   = head_rd;
         rf_d.data = head_data;
      end
   end

   // Starve counter, one-cycle bubble request and sticky protocol flag.
   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (starve_q != SC_W'(STARVE_LIMIT)) begin
         starve_d = starve_q + SC_W'(1);
      end
      stall_req_d = (starve_q == SC_W'(STARVE_LIMIT)) && !stall_req_q;
      proto_err_d = proto_err_q || (stall_req_q && pipe_we);
   end

   // Output and control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_q        <= '0;
         starve_q    <= '0;
         stall_req_q <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         rf_q        <= rf_d;
         starve_q    <= starve_d;
         stall_req_q <= stall_req_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign rf_we     = rf_q.we;
   assign rf_waddr  = rf_q.rd;
   assign rf_wdata  = rf_q.data;
   assign stall_req = stall_req_q;
   assign proto_err = proto_err_q;

endmodule
